ascon_dec_serial: RTL and testbench

Serial-interface decryption wrapper, the receive-side counterpart of the serial Ascon encryption top.
- Deserializes key, nonce, associated data, ciphertext and received tag.
- Launches an external Ascon decryption core through a start/ready handshake.
- Compares the computed tag against the received tag.
- Streams the recovered plaintext out one bit per cycle, only if the tag verifies.

---
 rtl/ascon_dec_serial.sv | 231 +++++++++++++++++++++++
 tb/tb_ascon_dec_serial.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_dec_serial.sv
// Serial-in Ascon decryption wrapper: loads operands bit-serially, drives an
// external core, checks the tag and streams plaintext out LSB first.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   keyxSI .. tagxSI           serial operand bits, MSB first
//   load_validxSI              qualifies the serial operand bits
//   decryption_startxSI        start request (ARMED / DONE)
//   core_*xDO, core_startxSO   operands and start pulse to the core
//   core_ptxDI, core_tagxDI    core results, valid with core_readyxDI
//   load_donexSO               operands loaded
//   plain_textxSO/validxSO     recovered plaintext, one bit per cycle
//   tag_okxSO, donexSO         tag verdict, operation complete
//   errorxSO                   core timeout
//
// Optional feature: define ASCON_DEC_TIMEOUT_EN to add a RUN-state watchdog
// of TIMEOUT cycles; otherwise errorxSO is constant 0.
module ascon_dec_serial #(
  parameter int K       = 128,
  parameter int L       = 32,
  parameter int Y       = 32,
  parameter int TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         keyxSI,
  input  logic         noncexSI,
  input  logic         associated_dataxSI,
  input  logic         cipher_textxSI,
  input  logic         tagxSI,
  input  logic         load_validxSI,
  input  logic         decryption_startxSI,
  output logic [K-1:0] core_keyxDO,
  output logic [127:0] core_noncexDO,
  output logic [L-1:0] core_adxDO,
  output logic [Y-1:0] core_ctxDO,
  output logic         core_startxSO,
  input  logic [Y-1:0] core_ptxDI,
  input  logic [127:0] core_tagxDI,
  input  logic         core_readyxDI,
  output logic         load_donexSO,
  output logic         plain_textxSO,
  output logic         plain_validxSO,
  output logic         tag_okxSO,
  output logic         donexSO,
  output logic         errorxSO
);

  localparam int M1   = (K > 128) ? K : 128;
  localparam int M2   = (M1 > L) ? M1 : L;
  localparam int NMAX = (M2 > Y) ? M2 : Y;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int OW   = (Y > 1) ? $clog2(Y) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(NMAX - 1);
  localparam logic [CW-1:0] C_K    = CW'(K);
  localparam logic [CW-1:0] C_N    = CW'(128);
  localparam logic [CW-1:0] C_L    = CW'(L);
  localparam logic [CW-1:0] C_Y    = CW'(Y);
  localparam logic [OW-1:0] O_LAST = OW'(Y - 1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lcnt;
  logic [K-1:0]  key_q, key_d;
  logic [127:0]  nonce_q, nonce_d;
  logic [L-1:0]  ad_q, ad_d;
  logic [Y-1:0]  ct_q, ct_d;
  logic [127:0]  tag_q, tag_d;
  logic [Y-1:0]  pt_q, pt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic          ok_q, ok_d;
  logic          start_q, start_d;
  logic          load_go;

`ifdef ASCON_DEC_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  // A fresh load is accepted from LOAD, and from DONE where it restarts
  // the bit count so the current bits become the first ones.
  assign load_go = load_validxSI &&
                   (state_q == S_LOAD || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt    = (state_q == S_DONE) ? '0 : cnt_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ad_d    = ad_q;
    ct_d    = ct_q;
    tag_d   = tag_q;
    pt_d    = pt_q;
    ocnt_d  = ocnt_q;
    ok_d    = ok_q;
    start_d = 1'b0;
`ifdef ASCON_DEC_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    if (load_go) begin
      // Narrow registers keep only the first bits of their stream.
      if (lcnt < C_K) key_d = {key_q[K-2:0], keyxSI};
      if (lcnt < C_N) nonce_d = {nonce_q[126:0], noncexSI};
      if (lcnt < C_L) ad_d = {ad_q[L-2:0], associated_dataxSI};
      if (lcnt < C_Y) ct_d = {ct_q[Y-2:0], cipher_textxSI};
      if (lcnt < C_N) tag_d = {tag_q[126:0], tagxSI};
      ok_d = 1'b0;
`ifdef ASCON_DEC_TIMEOUT_EN
      err_d = 1'b0;
`endif
      if (lcnt == C_LAST) begin
        state_d = S_ARMED;
        cnt_d   = '0;
      end else begin
        state_d = S_LOAD;
        cnt_d   = lcnt + 1'b1;
      end
    end else begin
      unique case (state_q)
        S_LOAD: ;
        S_ARMED, S_DONE: begin
          if (decryption_startxSI) begin
            start_d = 1'b1;
            ok_d    = 1'b0;
            state_d = S_RUN;
`ifdef ASCON_DEC_TIMEOUT_EN
            wd_d  = '0;
            err_d = 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (core_readyxDI) begin
            if (core_tagxDI == tag_q) begin
              pt_d    = core_ptxDI;
              ok_d    = 1'b1;
              ocnt_d  = '0;
              state_d = S_SHIFT;
            end else begin
              pt_d    = '0;
              ok_d    = 1'b0;
              state_d = S_DONE;
            end
          end
`ifdef ASCON_DEC_TIMEOUT_EN
          else if (wd_q == W_LAST) begin
            pt_d    = '0;
            ok_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end
        S_SHIFT: begin
          ocnt_d = ocnt_q + 1'b1;
          if (ocnt_q == O_LAST) state_d = S_DONE;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
      pt_q    <= '0;
      ocnt_q  <= '0;
      ok_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ad_q    <= ad_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
      pt_q    <= pt_d;
      ocnt_q  <= ocnt_d;
      ok_q    <= ok_d;
      start_q <= start_d;
    end
  end

`ifdef ASCON_DEC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign errorxSO = err_q;
`else
  // No watchdog: the comparison is constant false, so error stays 0.
  assign errorxSO = (TIMEOUT < 0);
`endif

  assign core_keyxDO    = key_q;
  assign core_noncexDO  = nonce_q;
  assign core_adxDO     = ad_q;
  assign core_ctxDO     = ct_q;
  assign core_startxSO  = start_q;
  assign load_donexSO   = (state_q != S_LOAD);
  assign plain_validxSO = (state_q == S_SHIFT);
  assign plain_textxSO  = plain_validxSO & pt_q[ocnt_q];
  assign tag_okxSO      = ok_q;
  assign donexSO        = (state_q == S_DONE);

endmodule

// File: tb/tb_ascon_dec_serial.sv
// Randomized bench for ascon_dec_serial with a mock core and a
// value-level reference of loaded operands and expected plaintext.
module tb_ascon_dec_serial;

  localparam int K = 128;
  localparam int L = 32;
  localparam int Y = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         keyxSI, noncexSI, associated_dataxSI;
  logic         cipher_textxSI, tagxSI;
  logic         load_validxSI, decryption_startxSI;
  logic [K-1:0] core_keyxDO;
  logic [127:0] core_noncexDO;
  logic [L-1:0] core_adxDO;
  logic [Y-1:0] core_ctxDO;
  logic         core_startxSO;
  logic [Y-1:0] core_ptxDI;
  logic [127:0] core_tagxDI;
  logic         core_readyxDI;
  logic         load_donexSO, plain_textxSO, plain_validxSO;
  logic         tag_okxSO, donexSO, errorxSO;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] m_key, m_nonce, m_tag;
  logic [31:0]  m_ad, m_ct;

  ascon_dec_serial #(.K(K), .L(L), .Y(Y)) dut (
    .clk(clk), .rst(rst),
    .keyxSI(keyxSI), .noncexSI(noncexSI),
    .associated_dataxSI(associated_dataxSI),
    .cipher_textxSI(cipher_textxSI), .tagxSI(tagxSI),
    .load_validxSI(load_validxSI),
    .decryption_startxSI(decryption_startxSI),
    .core_keyxDO(core_keyxDO), .core_noncexDO(core_noncexDO),
    .core_adxDO(core_adxDO), .core_ctxDO(core_ctxDO),
    .core_startxSO(core_startxSO),
    .core_ptxDI(core_ptxDI), .core_tagxDI(core_tagxDI),
    .core_readyxDI(core_readyxDI),
    .load_donexSO(load_donexSO),
    .plain_textxSO(plain_textxSO),
    .plain_validxSO(plain_validxSO),
    .tag_okxSO(tag_okxSO), .donexSO(donexSO),
    .errorxSO(errorxSO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_bits();
    keyxSI             = 1'($urandom);
    noncexSI           = 1'($urandom);
    associated_dataxSI = 1'($urandom);
    cipher_textxSI     = 1'($urandom);
    tagxSI             = 1'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_key"}, 128'(core_keyxDO), '0);
    chk({tag, "_nonce"}, 128'(core_noncexDO), '0);
    chk({tag, "_ad"}, 128'(core_adxDO), '0);
    chk({tag, "_ct"}, 128'(core_ctxDO), '0);
    chk({tag, "_outs"},
        128'({core_startxSO, load_donexSO, plain_textxSO,
              plain_validxSO, tag_okxSO, donexSO, errorxSO}), '0);
  endtask

  // Bits beyond a narrow operand's width are junk and must be dropped.
  task automatic do_load(input logic [127:0] k, input logic [127:0] n,
                         input logic [127:0] t, input logic [31:0] a,
                         input logic [31:0] c, input bit gaps,
                         input bit poke);
    int sbad = 0;
    for (int i = 0; i < 128; i++) begin
      if (gaps && i > 0) begin
        load_validxSI = 1'b0;
        rand_bits();
        decryption_startxSI = poke ? 1'($urandom) : 1'b0;
        tick();
        if (core_startxSO) sbad++;
      end
      keyxSI   = k[127-i];
      noncexSI = n[127-i];
      tagxSI   = t[127-i];
      associated_dataxSI = (i < 32) ? a[31-i] : 1'($urandom);
      cipher_textxSI     = (i < 32) ? c[31-i] : 1'($urandom);
      load_validxSI = 1'b1;
      decryption_startxSI = poke ? 1'($urandom) : 1'b0;
      if (i == 127) chk("load_done_early", 128'(load_donexSO), '0);
      tick();
      if (core_startxSO) sbad++;
      if (i == 0) chk("load_restart_done", 128'(donexSO), '0);
    end
    load_validxSI = 1'b0;
    decryption_startxSI = 1'b0;
    rand_bits();
    m_key = k; m_nonce = n; m_tag = t; m_ad = a; m_ct = c;
    chk("load_done", 128'(load_donexSO), 128'd1);
    chk("core_key", 128'(core_keyxDO), m_key);
    chk("core_nonce", 128'(core_noncexDO), m_nonce);
    chk("core_ad", 128'(core_adxDO), 128'(m_ad));
    chk("core_ct", 128'(core_ctxDO), 128'(m_ct));
    if (poke) chk("start_in_load", 128'(sbad), '0);
  endtask

  task automatic run_dec(input logic [31:0] pt, input bit bad,
                         input int dly, input int abort_at);
    int k, nb, zbad, done_at;
    logic [31:0] got;
    decryption_startxSI = 1'b1;
    tick();
    decryption_startxSI = 1'b0;
    chk("start_pulse", 128'(core_startxSO), 128'd1);
    chk("start_done_clr", 128'(donexSO), '0);
    chk("start_tagok_clr", 128'(tag_okxSO), '0);
    tick();
    chk("start_one_cycle", 128'(core_startxSO), '0);
    repeat (dly) tick();
    core_readyxDI = 1'b1;
    core_ptxDI    = pt;
    core_tagxDI   = bad ? m_tag ^ (128'd1 << $urandom_range(127))
                        : m_tag;
    tick();
    core_readyxDI = 1'b0;
    core_ptxDI    = $urandom;
    core_tagxDI   = {$urandom, $urandom, $urandom, $urandom};
    k = 1; nb = 0; zbad = 0; done_at = -1; got = '0;
    while (k <= Y + 4) begin
      if (abort_at >= 0 && nb == abort_at && plain_validxSO) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        return;
      end
      if (plain_validxSO) begin
        got[nb] = plain_textxSO;
        nb++;
      end else if (plain_textxSO) begin
        zbad++;
      end
      if (donexSO) begin
        done_at = k;
        break;
      end
      tick();
      k++;
    end
    chk("pt_bits", 128'(nb), bad ? '0 : 128'(Y));
    chk("pt_value", 128'(got), bad ? '0 : 128'(pt));
    chk("pt_idle_zero", 128'(zbad), '0);
    chk("tag_ok", 128'(tag_okxSO), 128'(!bad));
    chk("done_latency", 128'(done_at), bad ? 128'd1 : 128'(Y + 1));
    chk("error_low", 128'(errorxSO), '0);
    tick();
    chk("done_held", 128'(donexSO), 128'd1);
    chk("tag_ok_held", 128'(tag_okxSO), 128'(!bad));
  endtask

  initial begin
    logic [127:0] k0, n0, t0;
    rst = 1'b1;
    load_validxSI = 1'b0;
    decryption_startxSI = 1'b0;
    core_readyxDI = 1'b0;
    core_ptxDI = '0;
    core_tagxDI = '0;
    rand_bits();
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    k0 = 128'h000102030405060708090A0B0C0D0E0F;
    n0 = 128'h101112131415161718191A1B1C1D1E1F;
    t0 = {$urandom, $urandom, $urandom, $urandom};
    do_load(k0, n0, t0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0);
    run_dec(32'h12345678, 1'b0, 3, -1);
    run_dec(32'h12345678, 1'b1, 0, -1);

    do_load(k0, n0, t0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 1'b0);
    run_dec(32'h0F0F1234, 1'b0, 1, -1);

    do_load({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            $urandom, $urandom, 1'b1, 1'b1);
    core_readyxDI = 1'b1;
    core_ptxDI = $urandom;
    core_tagxDI = m_tag;
    tick();
    core_readyxDI = 1'b0;
    tick();
    chk("armed_ready_ignored",
        128'({core_startxSO, plain_validxSO, tag_okxSO, donexSO}), '0);
    chk("armed_still", 128'(load_donexSO), 128'd1);
    run_dec($urandom, 1'b0, 2, -1);

    do_load({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            $urandom, $urandom, 1'b0, 1'b0);
    run_dec($urandom, 1'b0, 0, 10);
    do_load({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            $urandom, $urandom, 1'b0, 1'b0);
    run_dec($urandom, 1'b0, 1, -1);

    for (int it = 0; it < 6; it++) begin
      do_load({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              $urandom, $urandom, 1'($urandom), 1'b0);
      run_dec($urandom, 1'($urandom), $urandom_range(5), -1);
    end

    decryption_startxSI = 1'b1;
    tick();
    decryption_startxSI = 1'b0;
    chk("hang_start", 128'(core_startxSO), 128'd1);
    repeat (300) tick();
    chk("hang_no_error", 128'(errorxSO), '0);
    chk("hang_not_done", 128'(donexSO), '0);
    chk("hang_no_valid", 128'(plain_validxSO), '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("final_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
